// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and sequencer sharing one serial_send transmitter between NUM_REQ byte producers.
// Optional hold-grant locking for contiguous multi-byte messages is enabled by `define UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16,
  localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW          = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   REQ_VALID,
  input  logic [8*NUM_REQ-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]   REQ_LOCK,
  output logic [NUM_REQ-1:0]   REQ_READY,
  output logic [7:0]           TX_DATA,
  output logic                 TX_WE,
  input  logic                 TX_BUSY,
  output logic [GW-1:0]        GRANT_ID,
  output logic                 ACTIVE,
  output logic                 ERR
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [GW-1:0]        ptr_r, win_idx_s, grant_id_r;
  logic [CW-1:0]        cnt_r;
  logic [NUM_REQ-1:0]   cand_s, ready_s;
  logic                 win_found_s, hs_s, timeout_s;
  logic [7:0]           tx_data_r;
  logic                 tx_we_r, active_r, err_r;

`ifdef UART_ARB_LOCK_EN
  logic                 lock_vld_r;
  logic [GW-1:0]        lock_own_r;

  // Candidate mask: only the lock owner may compete while a lock is held
  always_comb begin
    cand_s = REQ_VALID;
    if (lock_vld_r) begin
      cand_s = {NUM_REQ{1'b0}};
      cand_s[lock_own_r] = REQ_VALID[lock_own_r];
    end else begin
      cand_s = REQ_VALID;
    end
  end

  // Lock ownership: taken/dropped on handshake, dropped in IDLE when the owner lowers REQ_LOCK
  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_vld_r <= 1'b0;
      lock_own_r <= {GW{1'b0}};
    end else if (hs_s) begin
      lock_vld_r <= REQ_LOCK[win_idx_s];
      lock_own_r <= win_idx_s;
    end else if ((state_r == ST_IDLE) && lock_vld_r && !REQ_LOCK[lock_own_r]) begin
      lock_vld_r <= 1'b0;
    end
  end
`else
  logic lock_unused_s;
  assign lock_unused_s = ^REQ_LOCK;

  // Candidate mask: pure round-robin, every valid requester competes
  always_comb begin
    cand_s = REQ_VALID;
  end
`endif

  // Round-robin search upward from the requester after the last winner
  always_comb begin
    logic [GW-1:0] idx_v;
    win_found_s = 1'b0;
    win_idx_s   = {GW{1'b0}};
    idx_v       = {GW{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_v = GW'((int'(ptr_r) + k) % NUM_REQ);
      if (!win_found_s && cand_s[idx_v]) begin
        win_found_s = 1'b1;
        win_idx_s   = idx_v;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Handshake, ready vector and busy-timeout detection
  always_comb begin
    hs_s      = (state_r == ST_IDLE) && !RST && !TX_BUSY && win_found_s;
    timeout_s = (state_r == ST_WAIT_BUSY) && !TX_BUSY && (cnt_r == CW'(BUSY_TIMEOUT - 1));
    ready_s   = {NUM_REQ{1'b0}};
    if (hs_s) begin
      ready_s[win_idx_s] = 1'b1;
    end else begin
      ready_s = {NUM_REQ{1'b0}};
    end
  end

  // Next-state logic for the issue/wait sequence
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hs_s) state_nxt_s = ST_ISSUE;
        else      state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        state_nxt_s = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (TX_BUSY)        state_nxt_s = ST_WAIT_DONE;
        else if (timeout_s) state_nxt_s = ST_IDLE;
        else                state_nxt_s = ST_WAIT_BUSY;
      end
      ST_WAIT_DONE: begin
        if (!TX_BUSY) state_nxt_s = ST_IDLE;
        else          state_nxt_s = ST_WAIT_DONE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, pointer, timeout counter and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      ptr_r      <= GW'(NUM_REQ - 1);
      cnt_r      <= {CW{1'b0}};
      tx_data_r  <= 8'h00;
      tx_we_r    <= 1'b0;
      grant_id_r <= {GW{1'b0}};
      active_r   <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      tx_we_r  <= hs_s;
      active_r <= (state_nxt_s != ST_IDLE);
      err_r    <= timeout_s;
      if (hs_s) begin
        tx_data_r  <= REQ_DATA[{win_idx_s, 3'b000} +: 8];
        grant_id_r <= win_idx_s;
        ptr_r      <= win_idx_s;
        cnt_r      <= {CW{1'b0}};
      end else if ((state_r == ST_ISSUE) || (state_r == ST_WAIT_BUSY)) begin
        // counts cycles since TX_WE; WAIT_BUSY is left before it can pass BUSY_TIMEOUT-1
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign REQ_READY = ready_s;
  assign TX_DATA   = tx_data_r;
  assign TX_WE     = tx_we_r;
  assign GRANT_ID  = grant_id_r;
  assign ACTIVE    = active_r;
  assign ERR       = err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level reference model, serial_send busy model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [N-1:0]   REQ_VALID = '0;
  logic [8*N-1:0] REQ_DATA = '0;
  logic [N-1:0]   REQ_LOCK = '0;
  logic [N-1:0]   REQ_READY;
  logic [7:0]     TX_DATA;
  logic           TX_WE;
  logic           TX_BUSY = 1'b0;
  logic [1:0]     GRANT_ID;
  logic           ACTIVE;
  logic           ERR;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_LOCK(REQ_LOCK),
    .REQ_READY(REQ_READY), .TX_DATA(TX_DATA), .TX_WE(TX_WE), .TX_BUSY(TX_BUSY),
    .GRANT_ID(GRANT_ID), .ACTIVE(ACTIVE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // serial_send stand-in: busy rises 0..2 cycles after an accepted WE and lasts 2..6 cycles
  bit busy_en = 1'b1;
  bit ext_en  = 1'b0;
  bit to_en   = 1'b0;
  int dly = 0;
  int len = 0;
  always begin
    logic we_v, rst_v, ext_v;
    @(negedge CLK);
    we_v  = TX_WE;
    rst_v = RST;
    @(posedge CLK);
    #1;
    if (rst_v) begin
      dly = 0; len = 0;
    end else if (we_v && busy_en) begin
      dly = $urandom_range(0, 2);
      len = (to_en && ($urandom_range(0, 9) == 0)) ? 0 : $urandom_range(2, 6);
    end else if (dly > 0) begin
      dly--;
    end else if (len > 0) begin
      len--;
    end
    ext_v   = ext_en && ($urandom_range(0, 39) == 0);
    TX_BUSY = ((dly == 0) && (len > 0)) || ext_v;
  end

  // Reference model: frame timing tracked as cycle stamps, compared on every cycle
  int   cyc = 0;
  int   hs_cyc = -1000;
  int   err_cyc = -1000;
  bit   in_frame = 1'b0;
  bit   bseen = 1'b0;
  logic [7:0] m_data = 8'h00;
  int   m_gid = 0;
  int   m_ptr = N - 1;
  bit   m_lk = 1'b0;
  int   m_own = 0;

  always @(negedge CLK) begin
    int w;
    logic [N-1:0] er;
    w = -1;
    if (!RST && !in_frame && !TX_BUSY) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (w < 0 && REQ_VALID[idx] && (!m_lk || idx == m_own)) w = idx;
      end
    end
    er = (w >= 0) ? (N'(1) << w) : '0;
    chk("model_ready",  REQ_READY, er);
    chk("model_tx_we",  TX_WE, (cyc == hs_cyc + 1));
    chk("model_data",   TX_DATA, m_data);
    chk("model_grant",  GRANT_ID, m_gid);
    chk("model_active", ACTIVE, in_frame);
    chk("model_err",    ERR, (cyc == err_cyc));
    if (RST) begin
      hs_cyc = -1000; err_cyc = -1000; in_frame = 0; bseen = 0;
      m_data = 8'h00; m_gid = 0; m_ptr = N - 1; m_lk = 0; m_own = 0;
    end else if (w >= 0) begin
      hs_cyc = cyc; in_frame = 1; bseen = 0;
      m_data = REQ_DATA[8*w +: 8]; m_gid = w; m_ptr = w;
`ifdef UART_ARB_LOCK_EN
      m_lk = REQ_LOCK[w]; m_own = w;
`endif
    end else begin
`ifdef UART_ARB_LOCK_EN
      if (!in_frame && m_lk && !REQ_LOCK[m_own]) m_lk = 0;
`endif
      if (in_frame && cyc >= hs_cyc + 2) begin
        if (!bseen) begin
          if (TX_BUSY) bseen = 1;
          else if (cyc == hs_cyc + TO) begin in_frame = 0; err_cyc = cyc + 1; end
        end else if (!TX_BUSY) begin
          in_frame = 0;
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; REQ_VALID = '0; REQ_LOCK = '0;
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    @(negedge CLK);
    while (ACTIVE && c < 200) begin @(negedge CLK); c++; end
    chk(nm, ACTIVE, 1'b0);
    tick();
  endtask

  task automatic wait_busy_frame(input string nm);
    int c;
    c = 0;
    @(negedge CLK);
    while (!(ACTIVE && TX_BUSY) && c < 40) begin @(negedge CLK); c++; end
    chk(nm, ACTIVE && TX_BUSY, 1'b1);
  endtask

  logic [7:0] qd[N][$];
  bit         ql[N][$];
  int         sent_id[$];
  logic [7:0] sent_d[$];

  task automatic run_queues(input int max_cyc, input string nm);
    bit done;
    done = 0;
    sent_id.delete(); sent_d.delete();
    for (int c = 0; c < max_cyc && !done; c++) begin
      for (int i = 0; i < N; i++) begin
        REQ_VALID[i]       = (qd[i].size() > 0);
        REQ_DATA[8*i +: 8] = (qd[i].size() > 0) ? qd[i][0] : 8'h00;
        REQ_LOCK[i]        = (ql[i].size() > 0) ? ql[i][0] : 1'b0;
      end
      @(negedge CLK);
      chk({nm, "_we_while_busy"}, TX_WE & TX_BUSY, 1'b0);
      if (TX_WE) begin sent_id.push_back(GRANT_ID); sent_d.push_back(TX_DATA); end
      for (int i = 0; i < N; i++) begin
        if (REQ_READY[i] && REQ_VALID[i]) begin void'(qd[i].pop_front()); void'(ql[i].pop_front()); end
      end
      tick();
      done = !ACTIVE;
      for (int i = 0; i < N; i++) if (qd[i].size() > 0) done = 0;
    end
    REQ_VALID = '0; REQ_LOCK = '0;
    chk({nm, "_done"}, done, 1'b1);
  endtask

  initial begin
    int exp_id[5];
    logic [7:0] exp_d[5];
    int c;
    logic [N-1:0] hs;

    // reset state
    do_reset();
    @(negedge CLK);
    chk("rst_we", TX_WE, 1'b0); chk("rst_data", TX_DATA, 8'h00); chk("rst_gid", GRANT_ID, 2'd0);
    chk("rst_active", ACTIVE, 1'b0); chk("rst_err", ERR, 1'b0); chk("rst_ready", REQ_READY, 4'b0000);
    tick();

    // single byte
    REQ_DATA[7:0] = 8'h41; REQ_VALID = 4'b0001;
    @(negedge CLK); chk("t1_ready", REQ_READY, 4'b0001);
    tick(); REQ_VALID = '0;
    @(negedge CLK);
    chk("t1_we", TX_WE, 1'b1); chk("t1_data", TX_DATA, 8'h41);
    chk("t1_gid", GRANT_ID, 2'd0); chk("t1_active", ACTIVE, 1'b1);
    wait_idle("t1_idle");

    // round robin, requester 0 has a second byte
    do_reset();
    qd[0] = '{8'h10, 8'h10}; ql[0] = '{1'b0, 1'b0};
    qd[1] = '{8'h11}; ql[1] = '{1'b0};
    qd[2] = '{8'h12}; ql[2] = '{1'b0};
    qd[3] = '{8'h13}; ql[3] = '{1'b0};
    run_queues(300, "t2");
    exp_id = '{0, 1, 2, 3, 0};
    exp_d  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    chk("t2_count", sent_id.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < sent_id.size()) begin
        chk("t2_order", sent_id[i], exp_id[i]);
        chk("t2_byte", sent_d[i], exp_d[i]);
      end
    end

    // busy timeout
    do_reset(); busy_en = 0;
    REQ_DATA[23:16] = 8'h55; REQ_VALID = 4'b0100;
    @(negedge CLK); chk("t3_ready", REQ_READY, 4'b0100);
    tick(); REQ_VALID = '0;
    @(negedge CLK); chk("t3_we", TX_WE, 1'b1); chk("t3_data", TX_DATA, 8'h55);
    c = 0;
    do begin @(negedge CLK); c++; end while (!ERR && c < 40);
    chk("t3_err_delay", c, TO);
    chk("t3_active_at_err", ACTIVE, 1'b0);
    @(negedge CLK); chk("t3_err_pulse", ERR, 1'b0);
    busy_en = 1;
    tick();

    // reset in the middle of a frame
    do_reset();
    REQ_DATA[23:16] = 8'h22; REQ_VALID = 4'b0100;
    tick(); REQ_VALID = '0;
    wait_busy_frame("t4_frame");
    tick(); RST = 1'b1; tick(); RST = 1'b0;
    @(negedge CLK);
    chk("t4_we", TX_WE, 1'b0); chk("t4_data", TX_DATA, 8'h00); chk("t4_gid", GRANT_ID, 2'd0);
    chk("t4_active", ACTIVE, 1'b0); chk("t4_err", ERR, 1'b0);
    tick();
    REQ_DATA = 32'h44332211; REQ_VALID = 4'b1111;
    @(negedge CLK); chk("t4_ready", REQ_READY, 4'b0001);
    tick(); REQ_VALID = '0;
    wait_idle("t4_idle");

`ifdef UART_ARB_LOCK_EN
    // locked burst from requester 1 ahead of requester 3
    do_reset();
    qd[1] = '{8'hA1, 8'hA2, 8'hA3}; ql[1] = '{1'b1, 1'b1, 1'b0};
    qd[3] = '{8'h33}; ql[3] = '{1'b0};
    run_queues(300, "t5");
    chk("t5_count", sent_id.size(), 4);
    for (int i = 0; i < 4; i++) if (i < sent_id.size()) chk("t5_order", sent_id[i], (i < 3) ? 1 : 3);
`endif

    // withdrawal during another requester's frame
    do_reset();
    REQ_DATA = 32'h00EE0001; REQ_VALID = 4'b0101;
    @(negedge CLK); chk("t6_ready", REQ_READY, 4'b0001);
    tick(); REQ_VALID[0] = 1'b0;
    wait_busy_frame("t6_frame");
    tick(); REQ_VALID[2] = 1'b0; REQ_DATA[31:24] = 8'h33; REQ_VALID[3] = 1'b1;
    c = 0;
    @(negedge CLK);
    while (!TX_WE && c < 60) begin @(negedge CLK); c++; end
    chk("t6_gid", GRANT_ID, 2'd3); chk("t6_data", TX_DATA, 8'h33);
    tick(); REQ_VALID = '0;
    wait_idle("t6_idle");

    // randomized traffic with withdrawals, locks, stray busy, timeouts and resets
    do_reset(); ext_en = 1; to_en = 1;
    for (int n = 0; n < 4000; n++) begin
      @(negedge CLK);
      hs = REQ_READY & REQ_VALID;
      tick();
      if (RST) RST = 1'b0;
      else if ($urandom_range(0, 499) == 0) RST = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] || !REQ_VALID[i]) begin
          if (hs[i] ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0)) begin
            REQ_VALID[i] = 1'b1; REQ_DATA[8*i +: 8] = 8'($urandom); REQ_LOCK[i] = ($urandom_range(0, 3) == 0);
          end else begin
            REQ_VALID[i] = 1'b0; REQ_LOCK[i] = 1'b0;
          end
        end else if ($urandom_range(0, 24) == 0) begin
          REQ_VALID[i] = 1'b0; REQ_LOCK[i] = 1'b0;
        end
      end
    end
    REQ_VALID = '0; RST = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer sharing one serial_send UART transmitter between NUM_REQ byte producers. Accepts one byte per valid/ready handshake and issues it to serial_send as a one-cycle TX_WE pulse. Tracks serial_send BUSY so that a new byte is issued only after the previous frame has finished. Sits between the requester logic and serial_send, on the same CLK/RST.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BUSY_TIMEOUT, 16, maximum cycles to wait for TX_BUSY to rise after TX_WE before error abort

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous, active-high reset
REQ_VALID  input  NUM_REQ  per-requester byte valid
REQ_DATA  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
REQ_LOCK  input  NUM_REQ  per-requester hold-grant request (used only with the optional feature)
REQ_READY  output  NUM_REQ  per-requester accept, combinational, at most one bit high
TX_DATA  output  8  byte to serial_send DATA_IN, registered
TX_WE  output  1  write strobe to serial_send WE, one-cycle pulse, registered
TX_BUSY  input  1  serial_send BUSY
GRANT_ID  output  clog2(NUM_REQ)  index of the last accepted requester, registered
ACTIVE  output  1  high whenever the state is not IDLE
ERR  output  1  one-cycle pulse on BUSY timeout

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - TX_DATA = 0, TX_WE = 0, GRANT_ID = 0, ERR = 0, REQ_READY = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - Lock owner is cleared.
  - RST asserted mid-frame aborts the sequence; the same RST resets serial_send.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If TX_BUSY == 0 and any REQ_VALID is high, the winner is the first set REQ_VALID searching upward from pointer+1, wrapping modulo NUM_REQ.
  - REQ_READY[winner] = 1 in that same cycle. The handshake completes on that edge.
  - On the handshake edge: TX_DATA <= byte, GRANT_ID <= winner, pointer <= winner, go to ISSUE.
  - If TX_BUSY == 1 in IDLE (external or stale frame), no grant is made.
- ISSUE: TX_WE = 1 for exactly this cycle, then go to WAIT_BUSY.
  - Latency: handshake at cycle N, TX_WE high at cycle N+1.
- WAIT_BUSY:
  - TX_BUSY == 1: go to WAIT_DONE.
  - BUSY_TIMEOUT cycles elapse without TX_BUSY: ERR pulses 1 cycle, go to IDLE. The byte is dropped and is not retried.
- WAIT_DONE: TX_BUSY == 0, go to IDLE. Next grant is possible in the following cycle.
- REQ_READY is 0 in every state other than IDLE.
- Requester rules:
  - Holds REQ_DATA stable while REQ_VALID is high.
  - May deassert REQ_VALID before ready; no byte is lost in that case.
- TX_DATA holds its value until the next handshake.
- Throughput: at most one byte per serial frame plus 3 cycles of overhead.

Optional Feature:
UART_ARB_LOCK_EN:
- When defined:
  - A handshake with REQ_LOCK[winner] = 1 makes winner the lock owner.
  - While a lock owner exists, only the owner can win; other requesters stall even if valid.
  - Lock is released on an owner handshake with REQ_LOCK = 0 (that byte is still sent), or in IDLE when REQ_LOCK[owner] == 0.
  - Purpose: keeps multi-byte messages contiguous.
- When undefined: REQ_LOCK is ignored and arbitration is pure round-robin.

Test Plan:
1. Single byte: after reset, REQ_VALID = 4'b0001 with data 8'h41 -> REQ_READY[0] in the same cycle, TX_WE 1 cycle later with TX_DATA = 8'h41, GRANT_ID = 0, ACTIVE until BUSY falls.
2. Round-robin: all four requesters valid continuously, data 8'h10..8'h13 -> frames sent in order 0,1,2,3,0. No second TX_WE while TX_BUSY is high.
3. Timeout: tie TX_BUSY to 0, REQ_VALID[2] with 8'h55 -> TX_WE pulse, ERR pulses exactly BUSY_TIMEOUT=16 cycles later, back to IDLE.
4. Reset mid-frame: assert RST for 1 cycle during WAIT_DONE -> all outputs 0 next cycle, next grant goes to requester 0 even if the pointer was 2.
5. Lock (UART_ARB_LOCK_EN): requester 1 sends 3 bytes with REQ_LOCK = 1,1,0 while requester 3 is valid -> bytes sent as 1,1,1, then 3.
6. Withdrawal: requester 2 deasserts REQ_VALID in WAIT_DONE -> next grant goes to the next valid requester, and no byte from requester 2 appears on TX_DATA.
